ftdi_dir_sched: RTL and testbench
=================================

# ftdi_dir_sched

Direction scheduler for the FT2232H asynchronous FIFO bus. Sits between the FTDI/FPGA-FIFO status flags and the `ft2232h_async` byte engine. It decides which direction owns the shared half-duplex data bus: RX is host→FPGA, TX is FPGA→host. It enforces a bus-turnaround gap and a per-burst byte limit, so neither direction can starve the other. It also keeps wrapping byte counters per direction.

## Interface
Parameters:
- BURST_MAX, 64: max bytes per burst before the bus is re-arbitrated (1..255).
- TURN_CYC, 2: idle cycles inserted when bus direction changes (1..15).

Ports:
- iClk  in  1  system clock.
- iRst_n  in  1  reset; one clock; asynchronous, active-low.
- iRxF_n  in  1  FTDI RXF#; 0 = host byte available.
- iTxE_n  in  1  FTDI TXE#; 0 = FTDI can accept a byte.
- iRxWrFull  in  1  FPGA RX FIFO full.
- iTxRdEmpty  in  1  FPGA TX FIFO empty.
- iCoreBusy  in  1  engine mid-byte (RD#/WR# cycle in progress).
- iXferDone  in  1  one-cycle pulse from the engine per completed byte.
- oRxGrant  out  1  engine may start RX byte cycles.
- oTxGrant  out  1  engine may start TX byte cycles.
- oBusOe  out  1  FPGA may drive ioFifoData.
- oBusDir  out  1  current bus owner direction: 0 = RX, 1 = TX.
- oRxBytes  out  16  RX bytes completed, wraps 0xFFFF→0.
- oTxBytes  out  16  TX bytes completed, wraps.

## Operation
- Eligibility, combinational: rx_ok = !iRxF_n & !iRxWrFull; tx_ok = !iTxE_n & !iTxRdEmpty.
- States: IDLE, TURN, RX_BURST, TX_BURST.
- IDLE: target is the eligible direction. If both are eligible, target = !last_served; last_served resets to TX, so RX wins first. If target == oBusDir, go to the matching burst state. Otherwise load turn counter = TURN_CYC, set oBusDir = target, and go to TURN.
- TURN: decrement the counter each cycle. When it reaches 0, enter the burst state for oBusDir. Eligibility is not re-checked in TURN.
- RX_BURST/TX_BURST:
  - Grant held.
  - Burst counter clears on entry and increments on each iXferDone.
  - Exit to IDLE when iCoreBusy = 0 and either the burst count == BURST_MAX or the direction is no longer eligible.
  - On exit, last_served is set to the burst direction.
- Never leave a burst while iCoreBusy = 1. Grant drops only between bytes.
- If iXferDone and an eligibility drop occur in the same cycle, the byte is counted and then the block exits.
- A burst of exactly BURST_MAX bytes deasserts the grant the cycle after the BURST_MAX-th iXferDone, even if still eligible.
- oRxBytes/oTxBytes increment on iXferDone in the respective burst state. They increment in no other state.
- iXferDone outside a burst state is ignored.

## Timing
- Reset values: state IDLE, oRxGrant 0, oTxGrant 0, oBusOe 0, oBusDir 0 (RX), counters 0, last_served TX.
- Reset asserted mid-burst drops grants and oBusOe asynchronously, without waiting for a clock edge.
- All outputs are registered.
- Same-direction start: eligibility sampled at edge k in IDLE gives grant high after edge k+1.
- With turnaround, grant is high after edge k+1+TURN_CYC. oBusOe stays 0 throughout TURN.
- oBusOe = 1 only in TX_BURST. It rises with oTxGrant and falls with it.
- Exit: grant falls on the edge where the exit conditions are met. Next arbitration happens in IDLE one cycle later, so there is at least one cycle between grants.
- oBusDir changes only on the IDLE→TURN edge.

## Structure
- Shared package `ftdi_pkg`: state enum (IDLE, TURN, RX_BURST, TX_BURST) and constants DIR_RX = 0, DIR_TX = 1. The same constants are reused by `ft2232h_async`.
- One submodule: `ftdi_byte_counter`, a 16-bit wrapping counter with enable and async active-low clear. It is instantiated twice.
- The FSM, burst counter and turn counter stay in the top module.

## Test plan
- Reset, then iRxF_n = 0 only → oRxGrant high 1 cycle after sampling, no turnaround, oBusOe = 0. 3 iXferDone pulses, then iRxF_n = 1 → grant drops, oRxBytes = 3.
- RX burst active, then both RX and TX eligible → after the RX burst ends, TX is served: oBusDir→1, TURN_CYC = 2 idle cycles with oBusOe = 0, then oTxGrant and oBusOe rise together.
- BURST_MAX = 4, RX and TX continuously eligible → bursts alternate RX, TX, RX with exactly 4 bytes each. Counters advance by 4 per burst.
- iRxF_n rises while iCoreBusy = 1 → grant held until iCoreBusy = 0. A coincident iXferDone is counted.
- oTxBytes preloaded near 0xFFFF via 65535 bytes, then 2 more bytes → oTxBytes = 0x0001.
- iRst_n asserted mid-TX burst → oTxGrant, oBusOe and oBusDir go to 0 before the next clock edge. After release, the block sits in IDLE.

Source files
------------

// File: rtl/ftdi_pkg.sv
// Shared types and constants for the FT2232H async FIFO bus logic.
package ftdi_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TURN     = 2'd1,
        RX_BURST = 2'd2,
        TX_BURST = 2'd3
    } ftdi_state_e;

    localparam logic DIR_RX = 1'b0;
    localparam logic DIR_TX = 1'b1;

    localparam int unsigned BYTE_CNT_W  = 16;
    localparam int unsigned BURST_CNT_W = 8;
    localparam int unsigned TURN_CNT_W  = 4;

    function automatic ftdi_state_e burst_state(input logic dir);
        return (dir == DIR_TX) ? TX_BURST : RX_BURST;
    endfunction

endpackage

// File: rtl/ftdi_byte_counter.sv
// 16-bit wrapping byte counter with enable and async active-low clear.
module ftdi_byte_counter
    import ftdi_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_i,
    output logic [BYTE_CNT_W-1:0] cnt_o
);

    logic [BYTE_CNT_W-1:0] cnt_q;
    logic [BYTE_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = cnt_q + BYTE_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ftdi_dir_sched.sv
// Half-duplex bus direction scheduler: arbitrates RX/TX ownership with a
// turnaround gap and a per-burst byte limit, and counts completed bytes.
module ftdi_dir_sched
    import ftdi_pkg::*;
#(
    parameter int unsigned BURST_MAX = 64,
    parameter int unsigned TURN_CYC  = 2
) (
    input  logic                  iClk,
    input  logic                  iRst_n,
    input  logic                  iRxF_n,
    input  logic                  iTxE_n,
    input  logic                  iRxWrFull,
    input  logic                  iTxRdEmpty,
    input  logic                  iCoreBusy,
    input  logic                  iXferDone,
    output logic                  oRxGrant,
    output logic                  oTxGrant,
    output logic                  oBusOe,
    output logic                  oBusDir,
    output logic [BYTE_CNT_W-1:0] oRxBytes,
    output logic [BYTE_CNT_W-1:0] oTxBytes
);

    localparam logic [BURST_CNT_W-1:0] BURST_LIMIT = BURST_CNT_W'(BURST_MAX);

    ftdi_state_e            state_q, state_d;
    logic                   bus_dir_q, bus_dir_d;
    logic                   last_q, last_d;
    logic [TURN_CNT_W-1:0]  turn_q, turn_d;
    logic [BURST_CNT_W-1:0] burst_q, burst_d;
    logic                   rx_grant_q, tx_grant_q, bus_oe_q;

    logic rx_ok, tx_ok, dir_ok, target;
    logic rx_cnt_en, tx_cnt_en;

    assign rx_ok = ~iRxF_n & ~iRxWrFull;
    assign tx_ok = ~iTxE_n & ~iTxRdEmpty;

    // Next-state: arbitration in IDLE, turnaround countdown, burst exit rules
    always_comb begin
        state_d   = state_q;
        bus_dir_d = bus_dir_q;
        last_d    = last_q;
        turn_d    = turn_q;
        burst_d   = burst_q;
        target    = DIR_RX;
        dir_ok    = 1'b0;
        case (state_q)
            IDLE: begin
                burst_d = '0;
                if (rx_ok || tx_ok) begin
                    target = (rx_ok && tx_ok) ? ~last_q : tx_ok;
                    if (target == bus_dir_q) begin
                        state_d = burst_state(target);
                    end else begin
                        turn_d    = TURN_CNT_W'(TURN_CYC);
                        bus_dir_d = target;
                        state_d   = TURN;
                    end
                end
            end
            TURN: begin
                burst_d = '0;
                turn_d  = turn_q - TURN_CNT_W'(1);
                if (turn_d == '0) begin
                    state_d = burst_state(bus_dir_q);
                end
            end
            RX_BURST, TX_BURST: begin
                dir_ok = (state_q == TX_BURST) ? tx_ok : rx_ok;
                if (iXferDone && (burst_q != BURST_LIMIT)) begin
                    burst_d = burst_q + BURST_CNT_W'(1);
                end
                // Only release the bus between bytes
                if (!iCoreBusy && ((burst_q == BURST_LIMIT) || !dir_ok)) begin
                    state_d = IDLE;
                    last_d  = (state_q == TX_BURST) ? DIR_TX : DIR_RX;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q    <= IDLE;
            bus_dir_q  <= DIR_RX;
            last_q     <= DIR_TX;
            turn_q     <= '0;
            burst_q    <= '0;
            rx_grant_q <= 1'b0;
            tx_grant_q <= 1'b0;
            bus_oe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bus_dir_q  <= bus_dir_d;
            last_q     <= last_d;
            turn_q     <= turn_d;
            burst_q    <= burst_d;
            rx_grant_q <= (state_d == RX_BURST);
            tx_grant_q <= (state_d == TX_BURST);
            bus_oe_q   <= (state_d == TX_BURST);
        end
    end

    assign rx_cnt_en = iXferDone && (state_q == RX_BURST);
    assign tx_cnt_en = iXferDone && (state_q == TX_BURST);

    ftdi_byte_counter u_rx_cnt (
        .clk   (iClk),
        .rst_n (iRst_n),
        .en_i  (rx_cnt_en),
        .cnt_o (oRxBytes)
    );

    ftdi_byte_counter u_tx_cnt (
        .clk   (iClk),
        .rst_n (iRst_n),
        .en_i  (tx_cnt_en),
        .cnt_o (oTxBytes)
    );

    assign oRxGrant = rx_grant_q;
    assign oTxGrant = tx_grant_q;
    assign oBusOe   = bus_oe_q;
    assign oBusDir  = bus_dir_q;

endmodule

// File: tb/tb_ftdi_dir_sched.sv
// Bench for ftdi_dir_sched: directed scenarios checked against a cycle model
// plus literal expectations; a second instance exercises byte-counter wrap.
module tb_ftdi_dir_sched;

    localparam int BMAX = 4;
    localparam int TCYC = 2;

    logic clk;
    logic rst_n;
    logic rxf_n, txe_n, rxfull, txempty, busy, done;
    logic rxg, txg, oe, dir;
    logic [15:0] rxb, txb;

    logic w_txe_n, w_done;
    logic w_rxg, w_txg, w_oe, w_dir;
    logic [15:0] w_rxb, w_txb;

    int n_cmp;
    int n_fail;
    bit chk_en;
    int w_total;
    int w_bn;

    ftdi_dir_sched #(.BURST_MAX(BMAX), .TURN_CYC(TCYC)) u_dut (
        .iClk       (clk),
        .iRst_n     (rst_n),
        .iRxF_n     (rxf_n),
        .iTxE_n     (txe_n),
        .iRxWrFull  (rxfull),
        .iTxRdEmpty (txempty),
        .iCoreBusy  (busy),
        .iXferDone  (done),
        .oRxGrant   (rxg),
        .oTxGrant   (txg),
        .oBusOe     (oe),
        .oBusDir    (dir),
        .oRxBytes   (rxb),
        .oTxBytes   (txb)
    );

    ftdi_dir_sched #(.BURST_MAX(255), .TURN_CYC(1)) u_wrap (
        .iClk       (clk),
        .iRst_n     (rst_n),
        .iRxF_n     (1'b1),
        .iTxE_n     (w_txe_n),
        .iRxWrFull  (1'b0),
        .iTxRdEmpty (1'b0),
        .iCoreBusy  (1'b0),
        .iXferDone  (w_done),
        .oRxGrant   (w_rxg),
        .oTxGrant   (w_txg),
        .oBusOe     (w_oe),
        .oBusDir    (w_dir),
        .oRxBytes   (w_rxb),
        .oTxBytes   (w_txb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Bus-ownership model: serving a burst, waiting out a turnaround, or free
    bit m_serv;
    int m_wait;
    bit m_dir;
    bit m_last;
    int m_n;
    int unsigned m_rx;
    int unsigned m_tx;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_serv = 1'b0;
            m_wait = 0;
            m_dir  = 1'b0;
            m_last = 1'b1;
            m_n    = 0;
            m_rx   = 0;
            m_tx   = 0;
        end else begin : model_step
            bit rok, tok, still_ok, at_limit, want;
            rok = !rxf_n && !rxfull;
            tok = !txe_n && !txempty;
            if (m_serv) begin
                still_ok = m_dir ? tok : rok;
                at_limit = (m_n == BMAX);
                if (done) begin
                    m_n++;
                    if (m_dir) m_tx = (m_tx + 1) % 65536;
                    else       m_rx = (m_rx + 1) % 65536;
                end
                if (!busy && (at_limit || !still_ok)) begin
                    m_serv = 1'b0;
                    m_last = m_dir;
                end
            end else if (m_wait > 0) begin
                m_wait--;
                if (m_wait == 0) begin
                    m_serv = 1'b1;
                    m_n    = 0;
                end
            end else if (rok || tok) begin
                want = (rok && tok) ? !m_last : tok;
                if (want == m_dir) begin
                    m_serv = 1'b1;
                    m_n    = 0;
                end else begin
                    m_dir  = want;
                    m_wait = TCYC;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_rx_grant", rxg, 32'(m_serv && !m_dir));
            chk("m_tx_grant", txg, 32'(m_serv && m_dir));
            chk("m_bus_oe",   oe,  32'(m_serv && m_dir));
            chk("m_bus_dir",  dir, 32'(m_dir));
            chk("m_rx_bytes", rxb, m_rx);
            chk("m_tx_bytes", txb, m_tx);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_grant(input int budget);
        int c;
        c = 0;
        tick();
        while (!(rxg || txg) && c < budget) begin
            tick();
            c++;
        end
        chk("grant_timeout", 32'(rxg || txg), 32'd1);
    endtask

    task automatic run_wrap(input int target);
        int cyc;
        cyc = 0;
        while (w_total < target && cyc < 70000) begin
            tick();
            cyc++;
            if (w_txg && w_bn < 255) begin
                w_done = 1'b1;
                w_total++;
                w_bn++;
            end else begin
                w_done = 1'b0;
                if (!w_txg) w_bn = 0;
            end
        end
        tick();
        w_done = 1'b0;
        chk("wrap_byte_budget", w_total, target);
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; chk_en = 1'b0;
        w_total = 0; w_bn = 0;
        rst_n = 1'b0;
        rxf_n = 1'b1; txe_n = 1'b1; rxfull = 1'b0; txempty = 1'b0;
        busy = 1'b0; done = 1'b0;
        w_txe_n = 1'b1; w_done = 1'b0;

        repeat (2) tick();
        rst_n = 1'b1;
        chk_en = 1'b1;
        chk("rst_rx_grant", rxg, 0);
        chk("rst_tx_grant", txg, 0);
        chk("rst_bus_oe",   oe,  0);
        chk("rst_bus_dir",  dir, 0);
        chk("rst_rx_bytes", rxb, 0);
        chk("rst_tx_bytes", txb, 0);

        // RX only: grant one edge later, 3 bytes, then RX drops
        rxf_n = 1'b0;
        tick();
        chk("rx_start_grant", rxg, 1);
        chk("rx_start_oe",    oe,  0);
        chk("rx_start_dir",   dir, 0);
        done = 1'b1;
        repeat (3) tick();
        done = 1'b0; rxf_n = 1'b1;
        tick();
        chk("rx_end_grant", rxg, 0);
        chk("rx_end_bytes", rxb, 3);

        // RX burst hits the limit with TX pending: turnaround to TX
        rxf_n = 1'b0;
        tick();
        chk("rx2_grant", rxg, 1);
        txe_n = 1'b0;
        done = 1'b1;
        repeat (4) tick();
        done = 1'b0;
        chk("rx2_limit_hold", rxg, 1);
        tick();
        chk("rx2_exit_grant", rxg, 0);
        chk("rx2_exit_tx",    txg, 0);
        chk("rx2_exit_dir",   dir, 0);
        chk("rx2_exit_bytes", rxb, 7);
        tick();
        chk("turn1_dir", dir, 1);
        chk("turn1_oe",  oe,  0);
        chk("turn1_tx",  txg, 0);
        tick();
        chk("turn2_dir", dir, 1);
        chk("turn2_oe",  oe,  0);
        chk("turn2_tx",  txg, 0);
        tick();
        chk("tx_start_grant", txg, 1);
        chk("tx_start_oe",    oe,  1);

        // Alternation continues: TX burst of 4, then RX burst of 4
        done = 1'b1;
        repeat (4) tick();
        done = 1'b0;
        chk("tx_limit_hold", txg, 1);
        tick();
        chk("tx_exit_grant", txg, 0);
        chk("tx_exit_oe",    oe,  0);
        chk("tx_exit_bytes", txb, 4);
        wait_grant(10);
        chk("rx3_grant", rxg, 1);
        chk("rx3_dir",   dir, 0);
        done = 1'b1;
        repeat (4) tick();
        done = 1'b0;
        chk("rx3_bytes", rxb, 11);
        rxf_n = 1'b1; txe_n = 1'b1;
        tick();
        chk("rx3_exit_grant", rxg, 0);

        // Eligibility drops mid-byte: hold until the engine is idle
        rxf_n = 1'b0;
        tick();
        chk("busy_start_grant", rxg, 1);
        busy = 1'b1;
        tick();
        rxf_n = 1'b1;
        repeat (2) tick();
        chk("busy_hold_grant", rxg, 1);
        busy = 1'b0; done = 1'b1;
        tick();
        done = 1'b0;
        chk("busy_exit_grant", rxg, 0);
        chk("busy_exit_bytes", rxb, 12);

        // Reset asserted mid-TX burst clears outputs without a clock edge
        txe_n = 1'b0;
        wait_grant(10);
        chk("tx4_grant", txg, 1);
        chk("tx4_oe",    oe,  1);
        chk("tx4_dir",   dir, 1);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("tx4_bytes", txb, 5);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_tx_grant", txg, 0);
        chk("arst_bus_oe",   oe,  0);
        chk("arst_bus_dir",  dir, 0);
        chk("arst_tx_bytes", txb, 0);
        txe_n = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("post_rst_rx", rxg, 0);
        chk("post_rst_tx", txg, 0);
        chk("post_rst_dir", dir, 0);

        // Wrap instance: 65535 TX bytes, then 2 more
        w_txe_n = 1'b0;
        run_wrap(65535);
        chk("wrap_ffff", w_txb, 16'hFFFF);
        chk("wrap_rx0",  w_rxb, 0);
        run_wrap(65537);
        chk("wrap_0001", w_txb, 16'h0001);
        chk("wrap_dir",  w_dir, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
